cache_main_memory: RTL



---
 rtl/cache_main_memory.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cache_main_memory.sv
// Block-burst backing memory for the L1 data cache: 256 x 32-bit words, 4-word blocks, fixed access latency.
// Optional: define MEM_CRITICAL_WORD_FIRST_EN to start each burst at the requested word and wrap.
module cache_main_memory #(
  parameter int LATENCY      = 12,
  parameter int INIT_PATTERN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic        read_write_mem,
  input  logic [9:0]  address_mem,
  input  logic [31:0] write_data_mem,
  output logic [31:0] read_data_mem,
  output logic        Done,
  output logic [1:0]  beat,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam logic [5:0] LAT_LOAD = 6'(LATENCY - 1);

  // Power-up contents of word idx; the array stores the difference from this
  // pattern so that it can come up as all-zero without an initial block.
  function automatic logic [31:0] init_word(input logic [7:0] idx);
    if (INIT_PATTERN != 32'sd0) begin
      init_word = {24'd0, idx};
    end else begin
      init_word = 32'd0;
    end
  endfunction

  logic [31:0] mem_r [0:255] = '{default: 32'd0};

  state_t      state_r, state_s;
  logic [5:0]  lat_cnt_r, lat_cnt_s;
  logic [1:0]  beat_cnt_r, beat_cnt_s;
  logic [5:0]  base_r, base_s;
  logic [1:0]  offset_r, offset_s;
  logic        op_write_r, op_write_s;
  logic        done_s;
  logic [1:0]  beat_s;
  logic        busy_s;
  logic        rd_load_s;
  logic        mem_we_s;
  logic [1:0]  start_beat_s;
  logic [7:0]  rd_addr_s;
  logic [7:0]  wr_addr_s;
  logic        unused_s;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  assign start_beat_s = offset_r;
  assign unused_s     = ^address_mem[1:0];
`else
  assign start_beat_s = 2'd0;
  assign unused_s     = ^{offset_r, address_mem[1:0]};
`endif

  assign rd_addr_s = {base_s, beat_s};
  assign wr_addr_s = {base_r, beat};

  // Next-state, counter and output decode for the request FSM.
  always_comb begin
    state_s    = state_r;
    lat_cnt_s  = lat_cnt_r;
    beat_cnt_s = beat_cnt_r;
    base_s     = base_r;
    offset_s   = offset_r;
    op_write_s = op_write_r;
    done_s     = Done;
    beat_s     = beat;
    busy_s     = busy;
    rd_load_s  = 1'b0;
    mem_we_s   = 1'b0;
    case (state_r)
      IDLE: begin
        done_s = 1'b0;
        if (request) begin
          state_s    = WAIT;
          lat_cnt_s  = LAT_LOAD;
          base_s     = address_mem[9:4];
          offset_s   = address_mem[3:2];
          op_write_s = read_write_mem;
          busy_s     = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      WAIT: begin
        if (lat_cnt_r == 6'd0) begin
          state_s    = BURST;
          done_s     = 1'b1;
          beat_s     = start_beat_s;
          beat_cnt_s = 2'd0;
          rd_load_s  = ~op_write_r;
        end else begin
          lat_cnt_s = lat_cnt_r - 6'd1;
        end
      end
      BURST: begin
        // The word shown this cycle is committed on the edge that ends it.
        mem_we_s = op_write_r;
        if (beat_cnt_r == 2'd3) begin
          state_s = IDLE;
          done_s  = 1'b0;
          busy_s  = 1'b0;
        end else begin
          beat_cnt_s = beat_cnt_r + 2'd1;
          beat_s     = beat + 2'd1;
          rd_load_s  = ~op_write_r;
        end
      end
      default: begin
        state_s = IDLE;
        done_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      lat_cnt_r  <= 6'd0;
      beat_cnt_r <= 2'd0;
      base_r     <= 6'd0;
      offset_r   <= 2'd0;
      op_write_r <= 1'b0;
      Done       <= 1'b0;
      beat       <= 2'd0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      lat_cnt_r  <= lat_cnt_s;
      beat_cnt_r <= beat_cnt_s;
      base_r     <= base_s;
      offset_r   <= offset_s;
      op_write_r <= op_write_s;
      Done       <= done_s;
      beat       <= beat_s;
      busy       <= busy_s;
    end
  end

  // Read word register, loaded alongside the Done beat it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_mem <= 32'd0;
    end else if (rd_load_s) begin
      read_data_mem <= mem_r[rd_addr_s] ^ init_word(rd_addr_s);
    end
  end

  // Array write port; reset blocks the beat in flight but never clears contents.
  always_ff @(posedge clk) begin
    if (!reset && mem_we_s) begin
      mem_r[wr_addr_s] <= write_data_mem ^ init_word(wr_addr_s);
    end
  end

endmodule
